// File: rtl/lcd_bus_ctrl.sv
// 8080-style LCD bus controller: panel reset, init ROM playback, window setup, then pixel streaming.
// Each bus word takes two ticks; host/pixel ports see ready for one clk on an idle tick only.
module lcd_bus_ctrl #(
  parameter int DATA_W         = 16,
  parameter int CLK_DIV        = 20,
  parameter int RST_LOW_TICKS  = 25000,
  parameter int RST_WAIT_TICKS = 25000,
  parameter int INIT_LEN       = 134,
  parameter int ROM_AW         = 8,
  parameter int H_RES          = 854,
  parameter int V_RES          = 480
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W:0]   rom_data,
  input  logic              cmd_valid,
  input  logic              cmd_rs,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              frame_done,
  output logic [DATA_W-1:0] lcd_data,
  output logic              rst,
  output logic              cs,
  output logic              rs,
  output logic              wr,
  output logic              lcd_init_done
);

  localparam logic [2:0] ST_RST_LOW  = 3'd0;
  localparam logic [2:0] ST_RST_WAIT = 3'd1;
  localparam logic [2:0] ST_INIT     = 3'd2;
  localparam logic [2:0] ST_WIN      = 3'd3;
  localparam logic [2:0] ST_STREAM   = 3'd4;

  localparam int                DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0]       LOW_LAST   = 32'(RST_LOW_TICKS - 1);
  localparam logic [31:0]       WAIT_LAST  = 32'(RST_WAIT_TICKS - 1);
  localparam logic [ROM_AW-1:0] INIT_LAST  = ROM_AW'(INIT_LEN - 1);
  localparam logic [31:0]       FRAME_LAST = 32'(H_RES * V_RES - 1);
  localparam logic [15:0]       H_LAST     = 16'(H_RES - 1);
  localparam logic [15:0]       V_LAST     = 16'(V_RES - 1);
  localparam logic [3:0]        WIN_LAST   = 4'd10;
  localparam logic [DATA_W-1:0] OP_CASET   = DATA_W'(8'h2A);
  localparam logic [DATA_W-1:0] OP_PASET   = DATA_W'(8'h2B);
  localparam logic [DATA_W-1:0] OP_RAMWR   = DATA_W'(8'h2C);

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [31:0]       wait_cnt;
  logic              phase_b;
  logic [3:0]        win_idx;
  logic [31:0]       pix_cnt;
  logic              restart;

  logic              idle_slot;
  logic              cmd_take;
  logic              pix_take;
  logic              word_start;
  logic              word_rs;
  logic [DATA_W-1:0] word_dat;
  logic              win_rs;
  logic [DATA_W-1:0] win_dat;

  assign tick      = (div_cnt == DIV_LAST);
  assign idle_slot = (state == ST_STREAM) && !phase_b && tick;

  // A pending RAMWR restart owns the slot, so the host is held off too rather than accepted and lost.
  assign cmd_ready = idle_slot && !restart;
  assign pix_ready = cmd_ready && !cmd_valid;
  assign cmd_take  = cmd_valid && cmd_ready;
  assign pix_take  = pix_valid && pix_ready;

  always_comb begin
    win_rs  = 1'b1;
    win_dat = '0;
    case (win_idx)
      4'd0: begin
        win_rs  = 1'b0;
        win_dat = OP_CASET;
      end
      4'd3:  win_dat = DATA_W'(H_LAST[15:8]);
      4'd4:  win_dat = DATA_W'(H_LAST[7:0]);
      4'd5: begin
        win_rs  = 1'b0;
        win_dat = OP_PASET;
      end
      4'd8:  win_dat = DATA_W'(V_LAST[15:8]);
      4'd9:  win_dat = DATA_W'(V_LAST[7:0]);
      4'd10: begin
        win_rs  = 1'b0;
        win_dat = OP_RAMWR;
      end
      default: ;
    endcase
  end

  // Selects the word whose phase A is launched on this tick, if any.
  always_comb begin
    word_start = 1'b0;
    word_rs    = 1'b1;
    word_dat   = '0;
    case (state)
      ST_RST_WAIT: begin
        if (tick && (wait_cnt == WAIT_LAST)) begin
          word_start = 1'b1;
          word_rs    = rom_data[DATA_W];
          word_dat   = rom_data[DATA_W-1:0];
        end
      end
      ST_INIT: begin
        if (tick && !phase_b) begin
          word_start = 1'b1;
          word_rs    = rom_data[DATA_W];
          word_dat   = rom_data[DATA_W-1:0];
        end
      end
      ST_WIN: begin
        if (tick && !phase_b) begin
          word_start = 1'b1;
          word_rs    = win_rs;
          word_dat   = win_dat;
        end
      end
      ST_STREAM: begin
        if (idle_slot && restart) begin
          word_start = 1'b1;
          word_rs    = 1'b0;
          word_dat   = OP_RAMWR;
        end else if (cmd_take) begin
          word_start = 1'b1;
          word_rs    = cmd_rs;
          word_dat   = cmd_data;
        end else if (pix_take) begin
          word_start = 1'b1;
          word_rs    = 1'b1;
          word_dat   = pix_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_RST_LOW;
      div_cnt       <= '0;
      wait_cnt      <= '0;
      phase_b       <= 1'b0;
      win_idx       <= '0;
      pix_cnt       <= '0;
      restart       <= 1'b0;
      rom_addr      <= '0;
      rst           <= 1'b0;
      cs            <= 1'b1;
      rs            <= 1'b1;
      wr            <= 1'b1;
      lcd_data      <= '0;
      lcd_init_done <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;

      if (word_start) begin
        cs       <= 1'b0;
        wr       <= 1'b0;
        rs       <= word_rs;
        lcd_data <= word_dat;
        phase_b  <= 1'b1;
      end else if (tick && phase_b) begin
        wr      <= 1'b1;
        phase_b <= 1'b0;
      end

      if (tick) begin
        case (state)
          ST_RST_LOW: begin
            if (wait_cnt == LOW_LAST) begin
              rst      <= 1'b1;
              wait_cnt <= '0;
              state    <= ST_RST_WAIT;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
          ST_RST_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              wait_cnt <= '0;
              state    <= ST_INIT;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
          ST_INIT: begin
            if (phase_b) begin
              rom_addr <= rom_addr + 1'b1;
              if (rom_addr == INIT_LAST) state <= ST_WIN;
            end
          end
          ST_WIN: begin
            if (phase_b) begin
              if (win_idx == WIN_LAST) begin
                state         <= ST_STREAM;
                lcd_init_done <= 1'b1;
              end else begin
                win_idx <= win_idx + 4'd1;
              end
            end
          end
          ST_STREAM: begin
            if (!phase_b && restart) restart <= 1'b0;
          end
          default: state <= ST_RST_LOW;
        endcase
      end

      if (pix_take) begin
        if (pix_cnt == FRAME_LAST) begin
          pix_cnt    <= '0;
          frame_done <= 1'b1;
          restart    <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: cycle-level expected-bus model plus directed power-up, streaming,
// priority and mid-word reset scenarios.
module tb_lcd_bus_ctrl;

  localparam int DW = 16;
  localparam int C  = 2;
  localparam int RL = 4;
  localparam int RW = 3;
  localparam int IL = 3;
  localparam int AW = 2;
  localparam int HR = 4;
  localparam int VR = 2;

  localparam int NW         = IL + 11;
  localparam int T0         = (RL + RW) * C;
  localparam int DONE_CYC   = T0 + 2 * C * NW - C;
  localparam int STREAM_CYC = T0 + 2 * C * NW;
  localparam int FRAME      = HR * VR;

  typedef struct packed {
    logic          rs;
    logic [DW-1:0] d;
  } word_t;

  logic          clk;
  logic          reset;
  logic [AW-1:0] rom_addr;
  logic [DW:0]   rom_data;
  logic          cmd_valid;
  logic          cmd_rs;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          frame_done;
  logic [DW-1:0] lcd_data;
  logic          rst;
  logic          cs;
  logic          rs;
  logic          wr;
  logic          lcd_init_done;

  logic [DW:0] rom_mem [4];
  assign rom_data = rom_mem[rom_addr];

  word_t init_seq [NW];
  word_t exp_q [$];
  word_t dut_log [$];

  int errors = 0;
  int checks = 0;
  int cyc;

  lcd_bus_ctrl #(
    .DATA_W(DW), .CLK_DIV(C), .RST_LOW_TICKS(RL), .RST_WAIT_TICKS(RW),
    .INIT_LEN(IL), .ROM_AW(AW), .H_RES(HR), .V_RES(VR)
  ) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .frame_done(frame_done), .lcd_data(lcd_data), .rst(rst), .cs(cs), .rs(rs), .wr(wr),
    .lcd_init_done(lcd_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since the most recent reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic word_t mk(input logic r, input logic [DW-1:0] d);
    word_t w;
    w.rs = r;
    w.d  = d;
    return w;
  endfunction

  // Expected-bus model: fixed arithmetic schedule until streaming, then slot/priority rules.
  int            last_fall;
  logic          cur_rs;
  logic [DW-1:0] cur_d;
  bit            restart_pend;
  bit            fd_now;
  int            pix_cnt_m;
  int            k;
  bit            slot;
  logic          e_rst, e_cs, e_wr, e_rs, e_done, e_cready, e_pready;
  logic [DW-1:0] e_d;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_fall    = -1000;
        cur_rs       = 1'b0;
        cur_d        = 16'h002C;
        restart_pend = 1'b0;
        fd_now       = 1'b0;
        pix_cnt_m    = 0;
      end else begin
        e_rst  = (cyc >= RL * C);
        e_done = (cyc >= DONE_CYC);
        if (cyc < T0) begin
          e_cs = 1'b1; e_wr = 1'b1; e_rs = 1'b1; e_d = '0;
        end else if (cyc < STREAM_CYC) begin
          k    = (cyc - T0) / (2 * C);
          e_cs = 1'b0;
          e_wr = (((cyc - T0) % (2 * C)) >= C);
          e_rs = init_seq[k].rs;
          e_d  = init_seq[k].d;
        end else begin
          e_cs = 1'b0;
          e_wr = ((cyc - last_fall) >= C);
          e_rs = cur_rs;
          e_d  = cur_d;
        end
        slot     = (cyc >= STREAM_CYC - 1) && (((cyc + 1) % C) == 0) && (cyc + 1 >= last_fall + 2 * C);
        e_cready = slot && !restart_pend;
        e_pready = e_cready && !cmd_valid;

        chk("rst", 32'(rst), 32'(e_rst));
        chk("cs", 32'(cs), 32'(e_cs));
        chk("wr", 32'(wr), 32'(e_wr));
        chk("rs", 32'(rs), 32'(e_rs));
        chk("lcd_data", 32'(lcd_data), 32'(e_d));
        chk("lcd_init_done", 32'(lcd_init_done), 32'(e_done));
        chk("frame_done", 32'(frame_done), 32'(fd_now));
        chk("cmd_ready", 32'(cmd_ready), 32'(e_cready));
        chk("pix_ready", 32'(pix_ready), 32'(e_pready));

        fd_now = 1'b0;
        if (slot) begin
          if (restart_pend) begin
            restart_pend = 1'b0;
            last_fall = cyc + 1; cur_rs = 1'b0; cur_d = 16'h002C;
          end else if (cmd_valid) begin
            last_fall = cyc + 1; cur_rs = cmd_rs; cur_d = cmd_data;
          end else if (pix_valid) begin
            last_fall = cyc + 1; cur_rs = 1'b1; cur_d = pix_data;
            pix_cnt_m++;
            if (pix_cnt_m == FRAME) begin
              pix_cnt_m    = 0;
              fd_now       = 1'b1;
              restart_pend = 1'b1;
            end
          end
        end
      end
    end
  end

  // Word log: one entry per falling wr edge.
  logic prev_wr;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_wr = 1'b1;
      end else begin
        if (prev_wr && !wr) dut_log.push_back(mk(rs, lcd_data));
        prev_wr = wr;
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cyc != n) begin
      checks++; errors++;
      $display("FAIL wait_cyc: reached %0d wanted %0d", cyc, n);
    end
  endtask

  task automatic send_pix(input logic [DW-1:0] v);
    bit got = 0;
    int guard = 0;
    pix_valid = 1'b1;
    pix_data  = v;
    while (!got && guard < 200) begin
      @(negedge clk); got = pix_ready;
      @(posedge clk); #1;
      guard++;
    end
    pix_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL pix_accept: pixel %0h never taken", v);
    end
  endtask

  task automatic send_cmd(input logic r, input logic [DW-1:0] d);
    bit got = 0;
    int guard = 0;
    cmd_valid = 1'b1; cmd_rs = r; cmd_data = d;
    while (!got && guard < 200) begin
      @(negedge clk); got = cmd_ready;
      @(posedge clk); #1;
      guard++;
    end
    cmd_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL cmd_accept: word %0h never taken", d);
    end
  endtask

  task automatic send_both(input logic r, input logic [DW-1:0] d, input logic [DW-1:0] v);
    bit cg = 0, pg = 0, cr, pr;
    int guard = 0;
    cmd_valid = 1'b1; cmd_rs = r; cmd_data = d;
    pix_valid = 1'b1; pix_data = v;
    while (!(cg && pg) && guard < 200) begin
      @(negedge clk);
      cr = cmd_valid && cmd_ready;
      pr = pix_valid && pix_ready;
      if (cr) begin
        chk("prio_pix_ready_low", 32'(pix_ready), 32'd0);
        chk("prio_pixel_not_first", 32'(pg), 32'd0);
      end
      @(posedge clk); #1;
      guard++;
      if (cr) begin cmd_valid = 1'b0; cg = 1; end
      if (pr) begin pix_valid = 1'b0; pg = 1; end
    end
    cmd_valid = 1'b0;
    pix_valid = 1'b0;
    if (!(cg && pg)) begin
      checks++; errors++;
      $display("FAIL both_accept: cmd=%0d pix=%0d", cg, pg);
    end
  endtask

  task automatic cmp_log(input string tag);
    chk($sformatf("%s_len", tag), 32'(dut_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < dut_log.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 32'(dut_log[i]), 32'(exp_q[i]));
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = '0;
    pix_valid = 1'b0; pix_data = '0;
    rom_mem[0] = 17'h0_00FF;
    rom_mem[1] = 17'h1_0098;
    rom_mem[2] = 17'h1_0006;
    rom_mem[3] = 17'h0_0000;
    init_seq = '{mk(1'b0, 16'h00FF), mk(1'b1, 16'h0098), mk(1'b1, 16'h0006),
                 mk(1'b0, 16'h002A), mk(1'b1, 16'h0000), mk(1'b1, 16'h0000),
                 mk(1'b1, 16'h0000), mk(1'b1, 16'h0003), mk(1'b0, 16'h002B),
                 mk(1'b1, 16'h0000), mk(1'b1, 16'h0000), mk(1'b1, 16'h0000),
                 mk(1'b1, 16'h0001), mk(1'b0, 16'h002C)};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rst", 32'(rst), 32'd0);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_rs", 32'(rs), 32'd1);
    chk("rst_wr", 32'(wr), 32'd1);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_done", 32'(lcd_init_done), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b1;

    wait_cyc(7);  chk("rst_pin_still_low", 32'(rst), 32'd0);
    wait_cyc(8);  chk("rst_pin_high_at_8", 32'(rst), 32'd1);
    wait_cyc(13); chk("wr_high_at_13", 32'(wr), 32'd1);
    wait_cyc(14);
    chk("first_wr_low_at_14", 32'(wr), 32'd0);
    chk("first_word_rs", 32'(rs), 32'd0);
    chk("first_word_data", 32'(lcd_data), 32'h00FF);
    wait_cyc(67); chk("done_low_at_67", 32'(lcd_init_done), 32'd0);
    wait_cyc(68); chk("done_high_at_68", 32'(lcd_init_done), 32'd1);

    for (int v = 1; v <= 8; v++) send_pix(16'(v));
    chk("frame_done_on_8th", 32'(frame_done), 32'd1);
    chk("pixel8_cycle", 32'(cyc), 32'd98);
    send_pix(16'h0009);
    chk("pixel9_after_ramwr_cycle", 32'(cyc), 32'd106);
    send_both(1'b0, 16'h0036, 16'h000A);
    send_cmd(1'b1, 16'h0048);
    for (int v = 11; v <= 16; v++) send_pix(16'(v));
    chk("frame2_done_on_16th", 32'(frame_done), 32'd1);
    wait_cyc(cyc + 20);
    chk("idle_hold_data", 32'(lcd_data), 32'h002C);
    chk("idle_wr_high", 32'(wr), 32'd1);
    chk("idle_cs_low", 32'(cs), 32'd0);

    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back(init_seq[i]);
    for (int v = 1; v <= 8; v++) exp_q.push_back(mk(1'b1, 16'(v)));
    exp_q.push_back(mk(1'b0, 16'h002C));
    exp_q.push_back(mk(1'b1, 16'h0009));
    exp_q.push_back(mk(1'b0, 16'h0036));
    exp_q.push_back(mk(1'b1, 16'h000A));
    exp_q.push_back(mk(1'b1, 16'h0048));
    for (int v = 11; v <= 16; v++) exp_q.push_back(mk(1'b1, 16'(v)));
    exp_q.push_back(mk(1'b0, 16'h002C));
    cmp_log("run1");

    // Second power-up, interrupted during phase A of the second init word.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_cyc(18);
    chk("midword_wr_low", 32'(wr), 32'd0);
    chk("midword_data", 32'(lcd_data), 32'h0098);
    reset = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_wr", 32'(wr), 32'd1);
    chk("abort_rst", 32'(rst), 32'd0);
    chk("abort_rs", 32'(rs), 32'd1);
    chk("abort_data", 32'(lcd_data), 32'd0);
    chk("abort_rom_addr", 32'(rom_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    dut_log.delete();
    reset = 1'b1;

    wait_cyc(68);
    for (int v = 8'h11; v <= 8'h18; v++) send_pix(16'(v));
    chk("replay_frame_done", 32'(frame_done), 32'd1);
    chk("replay_pixel8_cycle", 32'(cyc), 32'd98);
    wait_cyc(cyc + 12);

    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back(init_seq[i]);
    for (int v = 8'h11; v <= 8'h18; v++) exp_q.push_back(mk(1'b1, 16'(v)));
    exp_q.push_back(mk(1'b0, 16'h002C));
    cmp_log("run2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
